// File: rtl/riscv_pkg.sv
// Shared load/store encodings and the memory-stage FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mau_state_e;

  // Access width from funct3; any encoding not listed is a word access.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  // Byte/half loads sign-extend unless they are the unsigned variants.
  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 != F3_BU) && (f3 != F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store strobes/data replication, load lane
// selection with sign/zero extension, and alignment check.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  acc_size_e  size;
  logic       sext;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  assign size = f3_size(funct3);
  assign sext = f3_signed(funct3);

  // Store side: byte enables and store data replicated across lanes.
  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (size)
      SZ_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
    if (!is_store) wstrb = '0;
  end

  // Load side: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    lane_b    = load_word[7:0];
    lane_h    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (addr_lo)
      2'd0:    lane_b = load_word[7:0];
      2'd1:    lane_b = load_word[15:8];
      2'd2:    lane_b = load_word[23:16];
      default: lane_b = load_word[31:24];
    endcase
    case (size)
      SZ_BYTE: load_data = {{24{sext & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{sext & lane_h[15]}}, lane_h};
      default: load_data = load_word;
    endcase
  end

  // Halfwords need an even address, words a multiple of four.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: issues one data-memory request per load/store,
// stalls upstream until the bus answers or times out, and registers the
// MEM/WB results.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  mau_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] cap_addr_q, cap_addr_d;
  logic [31:0] cap_wdata_q, cap_wdata_d;
  logic [3:0]  cap_wstrb_q, cap_wstrb_d;
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic [2:0]  cap_funct3_q, cap_funct3_d;
  logic        cap_regwrite_q, cap_regwrite_d;
  logic        cap_memtoreg_q, cap_memtoreg_d;
  logic        cap_memread_q, cap_memread_d;
  logic        cap_we_q, cap_we_d;

  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [31:0] wb_mem_data_q, wb_mem_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;

  logic        busy;
  logic        mem_op;
  logic        timeout_hit;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;

  assign busy        = (state_q == ST_BUSY);
  assign mem_op      = MemRead_in | MemWrite_in;
  assign timeout_hit = busy && (cnt_q == TMO_LAST);

  // One aligner serves both phases: incoming op while idle, captured op while busy.
  assign al_funct3  = busy ? cap_funct3_q : funct3_in;
  assign al_addr_lo = busy ? cap_addr_q[1:0] : alu_result_in[1:0];

  lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_store   (MemWrite_in),
    .store_data (rd2_in),
    .load_word  (dmem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misaligned (al_misaligned)
  );

  // Next-state, capture, write-back and stall logic.
  // The timeout cycle retires the aborted op (stall low) so the held
  // instruction is not re-issued once the FSM is back in IDLE.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cap_addr_d      = cap_addr_q;
    cap_wdata_d     = cap_wdata_q;
    cap_wstrb_d     = cap_wstrb_q;
    cap_rd_d        = cap_rd_q;
    cap_funct3_d    = cap_funct3_q;
    cap_regwrite_d  = cap_regwrite_q;
    cap_memtoreg_d  = cap_memtoreg_q;
    cap_memread_d   = cap_memread_q;
    cap_we_d        = cap_we_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_mem_data_d   = wb_mem_data_q;
    wb_rd_d         = wb_rd_q;
    wb_memtoreg_d   = wb_memtoreg_q;
    wb_regwrite_d   = 1'b0;
    misaligned_d    = 1'b0;
    bus_err_d       = 1'b0;
    stall_out       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op && !al_misaligned) begin
          cap_addr_d     = alu_result_in;
          cap_wdata_d    = al_wdata;
          cap_wstrb_d    = al_wstrb;
          cap_rd_d       = rd_in;
          cap_funct3_d   = funct3_in;
          cap_regwrite_d = RegWrite_in;
          cap_memtoreg_d = MemToReg_in;
          cap_memread_d  = MemRead_in;
          cap_we_d       = MemWrite_in;
          cnt_d          = '0;
          state_d        = ST_BUSY;
          stall_out      = 1'b1;
        end else begin
          wb_alu_result_d = alu_result_in;
          wb_mem_data_d   = '0;
          wb_rd_d         = rd_in;
          wb_memtoreg_d   = MemToReg_in;
          wb_regwrite_d   = RegWrite_in & ~mem_op;
          misaligned_d    = mem_op;
        end
      end
      ST_BUSY: begin
        if (dmem_ready) begin
          wb_alu_result_d = cap_addr_q;
          wb_mem_data_d   = cap_memread_q ? al_load_data : '0;
          wb_rd_d         = cap_rd_q;
          wb_memtoreg_d   = cap_memtoreg_q;
          wb_regwrite_d   = cap_regwrite_q;
          cnt_d           = '0;
          state_d         = ST_IDLE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture and MEM/WB registers; reset forces an idle, quiet stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      cap_addr_q      <= '0;
      cap_wdata_q     <= '0;
      cap_wstrb_q     <= '0;
      cap_rd_q        <= '0;
      cap_funct3_q    <= '0;
      cap_regwrite_q  <= 1'b0;
      cap_memtoreg_q  <= 1'b0;
      cap_memread_q   <= 1'b0;
      cap_we_q        <= 1'b0;
      wb_alu_result_q <= '0;
      wb_mem_data_q   <= '0;
      wb_rd_q         <= '0;
      wb_regwrite_q   <= 1'b0;
      wb_memtoreg_q   <= 1'b0;
      misaligned_q    <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cap_addr_q      <= cap_addr_d;
      cap_wdata_q     <= cap_wdata_d;
      cap_wstrb_q     <= cap_wstrb_d;
      cap_rd_q        <= cap_rd_d;
      cap_funct3_q    <= cap_funct3_d;
      cap_regwrite_q  <= cap_regwrite_d;
      cap_memtoreg_q  <= cap_memtoreg_d;
      cap_memread_q   <= cap_memread_d;
      cap_we_q        <= cap_we_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_mem_data_q   <= wb_mem_data_d;
      wb_rd_q         <= wb_rd_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_memtoreg_q   <= wb_memtoreg_d;
      misaligned_q    <= misaligned_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign dmem_req   = busy;
  assign dmem_we    = busy & cap_we_q;
  assign dmem_addr  = {cap_addr_q[31:2], 2'b00};
  assign dmem_wdata = cap_wdata_q;
  assign dmem_wstrb = busy ? cap_wstrb_q : '0;

  assign wb_alu_result = wb_alu_result_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_RegWrite   = wb_regwrite_q;
  assign wb_MemToReg   = wb_memtoreg_q;
  assign misaligned    = misaligned_q;
  assign bus_err       = bus_err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving bus-wait cycles before abort (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 alu_result_in  in  32  effective address, or result for non-memory ops.
REQ-005 rd2_in  in  32  store data.
REQ-006 rd_in  in  5  destination register.
REQ-007 funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 RegWrite_in / MemRead_in / MemWrite_in / MemToReg_in  in  1 each  control bits; all-zero is a bubble.
REQ-009 stall_out  out  1  combinational; upstream holds all inputs stable while high.
REQ-010 dmem_req  out  1  access request, held until dmem_ready or abort.
REQ-011 dmem_we  out  1  1 = store.
REQ-012 dmem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-013 dmem_wdata  out  32  store data replicated into the addressed byte lanes.
REQ-014 dmem_wstrb  out  4  byte enables; 0000 on loads.
REQ-015 dmem_rdata  in  32  load word, valid when dmem_ready=1.
REQ-016 dmem_ready  in  1  completes the outstanding request; ignored when no request.
REQ-017 wb_alu_result / wb_mem_data  out  32 each  MEM/WB registered result and extended load data.
REQ-018 wb_rd  out  5; wb_RegWrite, wb_MemToReg  out  1 each  registered MEM/WB controls.
REQ-019 misaligned  out  1  registered one-cycle pulse per misaligned access.
REQ-020 bus_err  out  1  registered one-cycle pulse per timed-out access.

Function
REQ-021 SHALL implement FSM IDLE/BUSY; a request is outstanding only in BUSY.
REQ-022 Non-memory op in IDLE: wb_* SHALL take inputs next edge (1-cycle latency), stall_out=0.
REQ-023 Aligned memory op in IDLE: SHALL capture address, data, strobe, rd, controls, funct3; enter BUSY; stall_out=1 that cycle.
REQ-024 BUSY: dmem_req=1 with captured fields; stall_out = ~dmem_ready; wb_RegWrite SHALL be 0 (bubble) each stalled cycle.
REQ-025 BUSY with dmem_ready=1: next edge SHALL load wb_* from captured fields plus extended rdata, return IDLE; minimum memory-op latency 2 cycles.
REQ-026 Back-to-back memory ops: IDLE after completion SHALL accept next op with no extra dead cycle beyond REQ-023.
REQ-027 Loads SHALL select lane by addr[1:0] (byte) or addr[1] (half); B/H sign-extend, BU/HU zero-extend; W passes through.
REQ-028 Store strobes: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; unlisted funct3 SHALL be treated as W.
REQ-029 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no bus access, no stall, wb_RegWrite=0, misaligned pulse next cycle.
REQ-030 8-bit wait counter SHALL clear on BUSY entry; at TIMEOUT cycles without dmem_ready: drop req, wb_RegWrite=0, bus_err pulse, IDLE.
REQ-031 dmem_ready and timeout in same cycle: ready SHALL win.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, dmem_req=0, counter=0, all wb_* and pulse outputs 0, even mid-access.
REQ-033 After reset release the unit SHALL accept an op on the first edge.

Structure
REQ-034 Shared package riscv_pkg SHALL hold funct3 load/store encodings and the IDLE/BUSY state type.
REQ-035 One combinational sub-module lsu_align SHALL perform lane selection, extension and strobe/wdata generation.

Verification
REQ-036 LW addr 0x100, ready after 3 cycles, rdata 0xDEADBEEF -> stall 4 cycles, wb_mem_data=0xDEADBEEF, wb_RegWrite=1.
REQ-037 LB addr 0x103, rdata 0x80FFFFFF -> wb_mem_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202, rd2=0x0000ABCD -> dmem_wstrb=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
REQ-039 LW addr 0x101 -> no dmem_req, misaligned one-cycle pulse, stall_out stays 0.
REQ-040 TIMEOUT=4, ready never asserted -> req drops after 4 BUSY cycles, bus_err pulse, wb_RegWrite=0; rst_n low mid-BUSY -> req=0 immediately.
